// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared types, defaults and sign helpers for the execute-stage
//             multiply/divide unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  // Default operand width of the multiply/divide unit.
  localparam int DATA_W_DEF = 64;

  // Working width of the sign helpers.  Callers zero-extend into this width
  // and slice the result back, so operands up to 127 bits are supported.
  localparam int MD_WIDE_W = 256;

  typedef logic [MD_WIDE_W-1:0] md_wide_t;

  // Operation encoding as seen on the 2-bit op input.
  typedef enum logic [1:0] {
    MULU = 2'b00,
    MUL  = 2'b01,
    DIVU = 2'b10,
    DIV  = 2'b11
  } md_op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  // Two's-complement negation when en is set, pass-through otherwise.
  function automatic md_wide_t neg2(input md_wide_t v, input logic en);
    return en ? (~v + md_wide_t'(1)) : v;
  endfunction

  // Magnitude of a zero-extended value whose sign bit is supplied separately.
  // The low bits of the result are the unsigned magnitude, so |MIN| is exact.
  function automatic md_wide_t abs_val(input md_wide_t v, input logic is_neg);
    return neg2(v, is_neg);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_datapath.sv
// ============================================================================
//  Module   : md_datapath
//  Purpose  : Operand capture, shift-add / restoring-divide iteration and
//             final sign correction for mul_div_unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              fix_wr,
  input  md_op_e            op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_by_zero
);

  // Working registers.  r_acc is the product high half (MUL) or the partial
  // remainder (DIV); r_shf is the multiplier / dividend that shifts out while
  // product bits / quotient bits shift in.  r_addend is the magnitude that is
  // added (MUL) or trial-subtracted (DIV) every step.
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_shf;
  logic [DATA_W-1:0] r_addend;
  logic [DATA_W-1:0] r_rs_raw;
  logic              r_is_div;
  logic              r_neg_res;
  logic              r_neg_rem;
  logic              r_dz;

  logic              w_rs_neg;
  logic              w_rt_neg;
  logic              w_is_div;
  md_wide_t          w_rs_wide;
  md_wide_t          w_rt_wide;
  md_wide_t          w_mag_a;
  md_wide_t          w_mag_b;

  logic [DATA_W:0]   w_mul_sum;
  logic [DATA_W-1:0] w_mul_acc;
  logic [DATA_W-1:0] w_mul_shf;
  logic [DATA_W+1:0] w_div_trial;
  logic              w_div_ok;
  logic [DATA_W-1:0] w_div_acc;
  logic [DATA_W-1:0] w_div_shf;

  md_wide_t          w_prod_raw;
  md_wide_t          w_prod_fix;
  md_wide_t          w_quo_raw;
  md_wide_t          w_quo_fix;
  md_wide_t          w_rem_raw;
  md_wide_t          w_rem_fix;
  logic [DATA_W-1:0] w_hi_res;
  logic [DATA_W-1:0] w_lo_res;
  logic              w_unused;

  // Operand magnitudes and sign flags for the op being started.
  always_comb begin
    w_is_div  = op[1];
    w_rs_neg  = op[0] & rs_val[DATA_W-1];
    w_rt_neg  = op[0] & rt_val[DATA_W-1];
    w_rs_wide = '0;
    w_rs_wide[DATA_W-1:0] = rs_val;
    w_rt_wide = '0;
    w_rt_wide[DATA_W-1:0] = rt_val;
    w_mag_a   = abs_val(w_rs_wide, w_rs_neg);
    w_mag_b   = abs_val(w_rt_wide, w_rt_neg);
  end

  // One iteration of each algorithm; the FSM picks which one applies.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc} + {1'b0, r_addend & {DATA_W{r_shf[0]}}};
    w_mul_acc   = w_mul_sum[DATA_W:1];
    w_mul_shf   = {w_mul_sum[0], r_shf[DATA_W-1:1]};
    // Two guard bits: {rem,bit} may reach 2^DATA_W, so the borrow sits above it.
    w_div_trial = {1'b0, r_acc, r_shf[DATA_W-1]} - {2'b00, r_addend};
    w_div_ok    = ~w_div_trial[DATA_W+1];
    w_div_acc   = w_div_ok ? w_div_trial[DATA_W-1:0]
                           : {r_acc[DATA_W-2:0], r_shf[DATA_W-1]};
    w_div_shf   = {r_shf[DATA_W-2:0], w_div_ok};
  end

  // Sign correction and divide-by-zero override of the final result.
  always_comb begin
    w_prod_raw = '0;
    w_prod_raw[2*DATA_W-1:0] = {r_acc, r_shf};
    w_prod_fix = neg2(w_prod_raw, r_neg_res);
    w_quo_raw  = '0;
    w_quo_raw[DATA_W-1:0] = r_shf;
    w_quo_fix  = neg2(w_quo_raw, r_neg_res);
    w_rem_raw  = '0;
    w_rem_raw[DATA_W-1:0] = r_acc;
    w_rem_fix  = neg2(w_rem_raw, r_neg_rem);
    if (r_is_div && r_dz) begin
      w_hi_res = r_rs_raw;
      w_lo_res = '1;
    end else if (r_is_div) begin
      w_hi_res = w_rem_fix[DATA_W-1:0];
      w_lo_res = w_quo_fix[DATA_W-1:0];
    end else begin
      w_hi_res = w_prod_fix[2*DATA_W-1:DATA_W];
      w_lo_res = w_prod_fix[DATA_W-1:0];
    end
  end

  // Upper bits of the wide helpers are zero by construction.
  assign w_unused = ^{w_mag_a[MD_WIDE_W-1:DATA_W], w_mag_b[MD_WIDE_W-1:DATA_W],
                      w_prod_fix[MD_WIDE_W-1:2*DATA_W],
                      w_quo_fix[MD_WIDE_W-1:DATA_W], w_rem_fix[MD_WIDE_W-1:DATA_W],
                      w_div_trial[DATA_W]};

  // Capture on start, iterate while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc     <= '0;
      r_shf     <= '0;
      r_addend  <= '0;
      r_rs_raw  <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
    end else if (load) begin
      r_acc     <= '0;
      r_shf     <= w_is_div ? w_mag_a[DATA_W-1:0] : w_mag_b[DATA_W-1:0];
      r_addend  <= w_is_div ? w_mag_b[DATA_W-1:0] : w_mag_a[DATA_W-1:0];
      r_rs_raw  <= rs_val;
      r_is_div  <= w_is_div;
      r_neg_res <= w_rs_neg ^ w_rt_neg;
      r_neg_rem <= w_rs_neg;
      r_dz      <= w_is_div && (rt_val == '0);
    end else if (step) begin
      r_acc     <= r_is_div ? w_div_acc : w_mul_acc;
      r_shf     <= r_is_div ? w_div_shf : w_mul_shf;
    end
  end

  // Architectural results change only on a completed, non-aborted op.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (fix_wr) begin
      hi          <= w_hi_res;
      lo          <= w_lo_res;
      div_by_zero <= r_is_div && r_dz;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Iterative one-bit-per-cycle multiply/divide unit producing a
//             HI/LO pair, with busy/done handshake and abort for flushes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_by_zero
);

  localparam int CNT_W = $clog2(DATA_W);

  md_state_e        r_state;
  md_state_e        w_state_next;
  logic [CNT_W-1:0] r_count;
  logic             r_done;
  logic             w_last;
  logic             w_load;
  logic             w_step;
  logic             w_fix_wr;

  assign w_last = (r_count == CNT_W'(DATA_W - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort always returns to IDLE and beats start.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start && !abort) w_state_next = RUN;
      RUN:     if (abort) w_state_next = IDLE;
               else if (w_last) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output/control decode from the current state.
  always_comb begin
    busy     = (r_state != IDLE);
    w_load   = (r_state == IDLE) && start && !abort;
    w_step   = (r_state == RUN) && !abort;
    w_fix_wr = (r_state == FIX) && !abort;
  end

  // Iteration counter: 0..DATA_W-1 across the RUN edges, zero elsewhere.
  always_ff @(posedge clk) begin
    if (reset || abort || (r_state != RUN) || w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // done pulses for one cycle after the result write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_fix_wr;
    end
  end

  assign done = r_done;

  md_datapath #(
    .DATA_W (DATA_W)
  ) u_datapath (
    .clk         (clk),
    .reset       (reset),
    .load        (w_load),
    .step        (w_step),
    .fix_wr      (w_fix_wr),
    .op          (md_op_e'(op)),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
//  Module   : tb_mul_div_unit
//  Purpose  : Directed self-checking bench for mul_div_unit (DATA_W = 64).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

  localparam int DATA_W = 64;
  localparam int LAT    = 65;
  localparam int TMO    = 200;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              abort;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              div_by_zero;

  int checks   = 0;
  int failures = 0;

  mul_div_unit #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Count negedges until done, noting whether busy stayed high meanwhile.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < TMO) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  // Issue one op and return at the negedge where done is high.
  task automatic run_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, busy_ok);
  endtask

  int   lat;
  logic bok;
  logic saw_done;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", hi, 64'd0);
    check("reset_lo", lo, 64'd0);
    check("reset_dz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;

    // MULU all-ones * 2
    run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, lat, bok);
    check("mulu_latency", 64'(lat), 64'(LAT));
    check("mulu_busy", 64'(bok), 64'd1);
    check("mulu_hi", hi, 64'd1);
    check("mulu_lo", lo, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);

    // MUL -3 * 7
    run_op(2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, lat, bok);
    check("mul_hi", hi, 64'hFFFF_FFFF_FFFF_FFFF);
    check("mul_lo", lo, 64'hFFFF_FFFF_FFFF_FFEB);

    // DIV -7 / 2
    run_op(2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat, bok);
    check("div_lo", lo, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_hi", hi, 64'hFFFF_FFFF_FFFF_FFFF);

    // DIVU 100 / 0
    run_op(2'b10, 64'd100, 64'd0, lat, bok);
    check("dz_latency", 64'(lat), 64'(LAT));
    check("dz_lo", lo, 64'hFFFF_FFFF_FFFF_FFFF);
    check("dz_hi", hi, 64'd100);
    check("dz_flag", 64'(div_by_zero), 64'd1);

    // DIVU 100 / 7 clears the flag
    run_op(2'b10, 64'd100, 64'd7, lat, bok);
    check("divu_lo", lo, 64'd14);
    check("divu_hi", hi, 64'd2);
    check("divu_flag", 64'(div_by_zero), 64'd0);

    // DIV MIN / -1
    run_op(2'b11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, bok);
    check("min_lo", lo, 64'h8000_0000_0000_0000);
    check("min_hi", hi, 64'd0);
    check("min_flag", 64'(div_by_zero), 64'd0);

    // Abort a DIVU at cycle 30
    @(negedge clk);
    op = 2'b10; rs_val = 64'd50; rt_val = 64'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    check("abort_lo_kept", lo, 64'h8000_0000_0000_0000);
    check("abort_hi_kept", hi, 64'd0);

    // start + abort together in IDLE
    start = 1'b1; abort = 1'b1; op = 2'b00; rs_val = 64'd9; rt_val = 64'd9;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("start_abort_busy2", 64'(busy), 64'd0);

    // Back-to-back: second start issued in the done cycle
    run_op(2'b10, 64'd100, 64'd7, lat, bok);
    check("b2b_first_lo", lo, 64'd14);
    op = 2'b00; rs_val = 64'd3; rt_val = 64'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_accepted", 64'(busy), 64'd1);
    wait_done(lat, bok);
    check("b2b_latency", 64'(lat), 64'(LAT));
    check("b2b_lo", lo, 64'd15);
    check("b2b_hi", hi, 64'd0);

    // start pulses while busy are ignored
    @(negedge clk);
    op = 2'b00; rs_val = 64'd6; rt_val = 64'd7; start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      start = ~i[0]; op = 2'b10; rs_val = 64'd1; rt_val = 64'd1;
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(lat, bok);
    check("ignore_latency", 64'(lat + 6), 64'(LAT));
    check("ignore_lo", lo, 64'd42);
    check("ignore_hi", hi, 64'd0);

    // reset at cycle 10 of an op
    @(negedge clk);
    op = 2'b00; rs_val = '1; rt_val = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_hi", hi, 64'd0);
    check("rst_mid_lo", lo, 64'd0);
    check("rst_mid_dz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
